id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register feeding the RV32I ALU: captures decoded operands, immediate and control.
//  Resolves operand forwarding from EX/MEM and MEM/WB and selects ALU inputs A/B.
//  Holds its entry under downstream backpressure or load-use hazard; supports flush on branch/jump.
//  Sits between decode and the ALU; all ALU inputs (A, B, ctrl) come from this block.
// PARAMETERS
//  XLEN  32  datapath width (only 32 supported)
// PORTS
//  clk             in   1     clock; all state updates on rising edge
//  rst             in   1     synchronous, active-high reset
//  id_valid        in   1     decode presents a valid instruction
//  id_ready        out  1     stage can accept: !valid_q | ex_fire
//  id_pc           in   32    instruction PC
//  id_rs1_data     in   32    register-file read, rs1
//  id_rs2_data     in   32    register-file read, rs2
//  id_imm          in   32    sign-extended immediate
//  id_rs1_addr     in   5     rs1 index
//  id_rs2_addr     in   5     rs2 index
//  id_rd_addr      in   5     destination index
//  id_alu_ctrl     in   4     ALU op code (funct7[5],funct3 packing)
//  id_src_a_pc     in   1     1: A = PC, 0: A = rs1
//  id_src_b_imm    in   1     1: B = imm, 0: B = rs2
//  id_reg_write    in   1     instruction writes rd
//  flush           in   1     kill entry and any incoming instruction
//  exmem_rd        in   5     EX/MEM destination
//  exmem_reg_write in   1     EX/MEM writes rd
//  exmem_mem_read  in   1     EX/MEM is a load (result not yet valid)
//  exmem_result    in   32    EX/MEM ALU result
//  memwb_rd        in   5     MEM/WB destination
//  memwb_reg_write in   1     MEM/WB writes rd
//  memwb_result    in   32    MEM/WB writeback value
//  ex_valid        out  1     ALU inputs valid: valid_q & !load_use
//  ex_ready        in   1     downstream accepts; ex_fire = ex_valid & ex_ready
//  alu_a           out  32    ALU operand A
//  alu_b           out  32    ALU operand B
//  alu_ctrl        out  4     registered ALU op code
//  ex_store_data   out  32    forwarded rs2 (store data), independent of src_b_imm
//  ex_rd_addr      out  5     registered rd
//  ex_reg_write    out  1     registered reg_write; 0 whenever valid_q = 0
//  ex_pc           out  32    registered PC
// BEHAVIOUR
//  - Reset: valid_q=0, all data/control regs 0 (alu_ctrl=4'b0000, rd=0, reg_write=0); ex_valid=0.
//  - Latency: 1 cycle; id fire (id_valid & id_ready) at edge N -> ex_valid high after edge N.
//  - Load when id_ready & id_valid & !flush; valid_q<=1. id_ready & !id_valid -> valid_q<=0 (bubble).
//  - Hold: valid_q & !ex_fire -> all regs keep value except rs1/rs2 capture (below).
//  - Flush: valid_q<=0 next edge, overrides load and hold; id_ready is not gated by flush.
//  - Forwarding (combinational, per operand rsX, X=1,2):
//    exmem_reg_write & exmem_rd==rsX & rsX!=0 -> exmem_result;
//    else memwb_reg_write & memwb_rd==rsX & rsX!=0 -> memwb_result; else registered rsX data.
//    EX/MEM strictly higher priority than MEM/WB. x0 never forwarded (reads registered value).
//  - Hold capture: while valid_q & !ex_fire, if MEM/WB forwarding selects rsX, write memwb_result
//    into rsX register so a retiring producer's value is not lost.
//  - load_use = valid_q & exmem_mem_read & exmem_reg_write & exmem_rd!=0 &
//    ((exmem_rd==rs1 & !src_a_pc) | (exmem_rd==rs2)); forces ex_valid=0, entry held.
//  - alu_a = src_a_pc ? pc_q : fwd_rs1; alu_b = src_b_imm ? imm_q : fwd_rs2.
//  - All arithmetic is 32-bit pass-through; no width extension in this block.
//  - Simultaneous flush + ex_fire: flush wins; no new load that cycle.
// TESTING
//  - Reset mid-hold (valid_q=1, ex_ready=0), rst=1 one cycle -> ex_valid=0, alu_ctrl=0, id_ready=1.
//  - addi: rs1_data=5, imm=7, src_b_imm=1, ctrl=0000 -> next cycle alu_a=5, alu_b=7, ex_valid=1.
//  - Double forward: rs1=3, exmem_rd=3 result=0xAA, memwb_rd=3 result=0xBB -> alu_a=0xAA; rs1=0 -> rf value.
//  - Load-use: exmem_mem_read=1, exmem_rd=rs2=4 -> ex_valid=0, id_ready=0; drop mem_read -> ex_valid=1.
//  - Hold capture: ex_ready=0, memwb_rd=rs1=6 result=0x1234 one cycle, then idle -> alu_a=0x1234 held.
//  - Flush with id_valid=1, ex_ready=1 -> valid_q=0 next cycle, incoming instr dropped, ex_reg_write=0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the RV32I ALU.
// Forwards from EX/MEM and MEM/WB, detects load-use, holds and flushes.
module id_ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rs1_addr,
    input  logic [4:0]      id_rs2_addr,
    input  logic [4:0]      id_rd_addr,
    input  logic [3:0]      id_alu_ctrl,
    input  logic            id_src_a_pc,
    input  logic            id_src_b_imm,
    input  logic            id_reg_write,
    input  logic            flush,
    input  logic [4:0]      exmem_rd,
    input  logic            exmem_reg_write,
    input  logic            exmem_mem_read,
    input  logic [XLEN-1:0] exmem_result,
    input  logic [4:0]      memwb_rd,
    input  logic            memwb_reg_write,
    input  logic [XLEN-1:0] memwb_result,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_ctrl,
    output logic [XLEN-1:0] ex_store_data,
    output logic [4:0]      ex_rd_addr,
    output logic            ex_reg_write,
    output logic [XLEN-1:0] ex_pc
);

    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] rs1_q;
    logic [XLEN-1:0] rs2_q;
    logic [XLEN-1:0] imm_q;
    logic [4:0]      rs1a_q;
    logic [4:0]      rs2a_q;
    logic [4:0]      rd_q;
    logic [3:0]      ctrl_q;
    logic            src_a_pc_q;
    logic            src_b_imm_q;
    logic            reg_write_q;

    logic            ex1;
    logic            ex2;
    logic            wb1;
    logic            wb2;
    logic            load_use;
    logic            ex_fire;
    logic [XLEN-1:0] fwd1;
    logic [XLEN-1:0] fwd2;

    assign ex1 = exmem_reg_write && (exmem_rd == rs1a_q) && (rs1a_q != 5'd0);
    assign ex2 = exmem_reg_write && (exmem_rd == rs2a_q) && (rs2a_q != 5'd0);
    assign wb1 = memwb_reg_write && (memwb_rd == rs1a_q) && (rs1a_q != 5'd0);
    assign wb2 = memwb_reg_write && (memwb_rd == rs2a_q) && (rs2a_q != 5'd0);

    assign fwd1 = ex1 ? exmem_result : (wb1 ? memwb_result : rs1_q);
    assign fwd2 = ex2 ? exmem_result : (wb2 ? memwb_result : rs2_q);

    // rs2 always counts: stores need it even when B is the immediate
    assign load_use = valid_q && exmem_mem_read && exmem_reg_write
                      && (exmem_rd != 5'd0)
                      && (((exmem_rd == rs1a_q) && !src_a_pc_q)
                          || (exmem_rd == rs2a_q));

    assign ex_valid = valid_q && !load_use;
    assign ex_fire  = ex_valid && ex_ready;
    assign id_ready = !valid_q || ex_fire;

    assign alu_a         = src_a_pc_q ? pc_q : fwd1;
    assign alu_b         = src_b_imm_q ? imm_q : fwd2;
    assign alu_ctrl      = ctrl_q;
    assign ex_store_data = fwd2;
    assign ex_rd_addr    = rd_q;
    assign ex_reg_write  = valid_q && reg_write_q;
    assign ex_pc         = pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            imm_q       <= '0;
            rs1a_q      <= 5'd0;
            rs2a_q      <= 5'd0;
            rd_q        <= 5'd0;
            ctrl_q      <= 4'b0000;
            src_a_pc_q  <= 1'b0;
            src_b_imm_q <= 1'b0;
            reg_write_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (id_ready) begin
            valid_q <= id_valid;
            if (id_valid) begin
                pc_q        <= id_pc;
                rs1_q       <= id_rs1_data;
                rs2_q       <= id_rs2_data;
                imm_q       <= id_imm;
                rs1a_q      <= id_rs1_addr;
                rs2a_q      <= id_rs2_addr;
                rd_q        <= id_rd_addr;
                ctrl_q      <= id_alu_ctrl;
                src_a_pc_q  <= id_src_a_pc;
                src_b_imm_q <= id_src_b_imm;
                reg_write_q <= id_reg_write;
            end
        end else begin
            // Retiring MEM/WB producer leaves next cycle; keep its value
            if (wb1 && !ex1) rs1_q <= memwb_result;
            if (wb2 && !ex2) rs2_q <= memwb_result;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed issue, monitor pops on fire.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic [31:0] id_imm;
    logic [4:0]  id_rs1_addr;
    logic [4:0]  id_rs2_addr;
    logic [4:0]  id_rd_addr;
    logic [3:0]  id_alu_ctrl;
    logic        id_src_a_pc;
    logic        id_src_b_imm;
    logic        id_reg_write;
    logic        flush;
    logic [4:0]  exmem_rd;
    logic        exmem_reg_write;
    logic        exmem_mem_read;
    logic [31:0] exmem_result;
    logic [4:0]  memwb_rd;
    logic        memwb_reg_write;
    logic [31:0] memwb_result;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctrl;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd_addr;
    logic        ex_reg_write;
    logic [31:0] ex_pc;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic [31:0] store;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] pc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rd_addr(id_rd_addr), .id_alu_ctrl(id_alu_ctrl),
        .id_src_a_pc(id_src_a_pc), .id_src_b_imm(id_src_b_imm),
        .id_reg_write(id_reg_write), .flush(flush),
        .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write),
        .exmem_mem_read(exmem_mem_read), .exmem_result(exmem_result),
        .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write),
        .memwb_result(memwb_result),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr),
        .ex_reg_write(ex_reg_write), .ex_pc(ex_pc)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every accepted output must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && ex_valid && ex_ready) begin
            exp_t act;
            exp_t e;
            act = '{alu_a, alu_b, alu_ctrl, ex_store_data,
                    ex_rd_addr, ex_reg_write, ex_pc};
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_fire: got %h expected none", act);
            end else begin
                e = q.pop_front();
                if (act !== e) begin
                    failures++;
                    $display("FAIL fire_compare: got %h expected %h",
                             act, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_fwd();
        exmem_rd = 0; exmem_reg_write = 0; exmem_mem_read = 0;
        exmem_result = 0; memwb_rd = 0; memwb_reg_write = 0;
        memwb_result = 0;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [31:0] r1d,
                         input logic [31:0] r2d, input logic [31:0] imm,
                         input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rd, input logic [3:0] ctrl,
                         input logic sa, input logic sb, input logic rw);
        id_valid = 1; id_pc = pc; id_rs1_data = r1d; id_rs2_data = r2d;
        id_imm = imm; id_rs1_addr = r1; id_rs2_addr = r2; id_rd_addr = rd;
        id_alu_ctrl = ctrl; id_src_a_pc = sa; id_src_b_imm = sb;
        id_reg_write = rw;
        step();
        id_valid = 0;
    endtask

    initial begin
        rst = 1; id_valid = 0; flush = 0; ex_ready = 1;
        id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
        id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0;
        id_alu_ctrl = 0; id_src_a_pc = 0; id_src_b_imm = 0;
        id_reg_write = 0;
        clr_fwd();
        step(); step();
        rst = 0;
        @(negedge clk);
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_id_ready", 32'(id_ready), 32'd1);
        chk("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
        chk("rst_reg_write", 32'(ex_reg_write), 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);

        // addi x1, x1, 7
        q.push_back('{32'd5, 32'd7, 4'b0000, 32'd9, 5'd1, 1'b1, 32'h100});
        issue(32'h100, 5, 9, 7, 1, 2, 1, 4'b0000, 0, 1, 1);
        @(negedge clk);
        chk("addi_ex_valid", 32'(ex_valid), 32'd1);
        step();

        // EX/MEM beats MEM/WB on rs1=3
        q.push_back('{32'hAA, 32'd0, 4'b0010, 32'h22, 5'd5, 1'b1, 32'h104});
        issue(32'h104, 32'h11, 32'h22, 0, 3, 0, 5, 4'b0010, 0, 1, 1);
        exmem_rd = 3; exmem_reg_write = 1; exmem_result = 32'hAA;
        memwb_rd = 3; memwb_reg_write = 1; memwb_result = 32'hBB;
        step();
        clr_fwd();

        // x0 never forwarded
        q.push_back('{32'h33, 32'd0, 4'b0000, 32'h0, 5'd6, 1'b1, 32'h108});
        issue(32'h108, 32'h33, 0, 0, 0, 0, 6, 4'b0000, 0, 1, 1);
        exmem_rd = 0; exmem_reg_write = 1; exmem_result = 32'hAA;
        memwb_rd = 0; memwb_reg_write = 1; memwb_result = 32'hBB;
        step();
        clr_fwd();

        // MEM/WB only on rs2, B = rs2; A = PC
        q.push_back('{32'h10C, 32'hBB, 4'b1101, 32'hBB, 5'd7, 1'b0,
                      32'h10C});
        issue(32'h10C, 32'h1, 32'h2, 32'h3, 1, 7, 7, 4'b1101, 1, 0, 0);
        exmem_rd = 8; exmem_reg_write = 1; exmem_result = 32'hAA;
        memwb_rd = 7; memwb_reg_write = 1; memwb_result = 32'hBB;
        step();
        clr_fwd();

        // Load-use on rs2=4
        issue(32'h110, 32'h1, 32'h44, 0, 1, 4, 9, 4'b0000, 0, 0, 1);
        exmem_mem_read = 1; exmem_reg_write = 1; exmem_rd = 4;
        exmem_result = 32'hDEAD;
        @(negedge clk);
        chk("lu_ex_valid", 32'(ex_valid), 32'd0);
        chk("lu_id_ready", 32'(id_ready), 32'd0);
        step();
        @(negedge clk);
        chk("lu_hold_ex_valid", 32'(ex_valid), 32'd0);
        step();
        q.push_back('{32'h1, 32'hDEAD, 4'b0000, 32'hDEAD, 5'd9, 1'b1,
                      32'h110});
        exmem_mem_read = 0;
        @(negedge clk);
        chk("lu_release_ex_valid", 32'(ex_valid), 32'd1);
        step();
        clr_fwd();

        // Hold capture of retiring MEM/WB value into rs1
        ex_ready = 0;
        issue(32'h114, 32'h1, 32'h0, 32'h3, 6, 0, 10, 4'b1000, 0, 1, 1);
        memwb_rd = 6; memwb_reg_write = 1; memwb_result = 32'h1234;
        @(negedge clk);
        chk("cap_fwd_a", alu_a, 32'h1234);
        step();
        clr_fwd();
        @(negedge clk);
        chk("cap_held_a", alu_a, 32'h1234);
        chk("cap_id_ready", 32'(id_ready), 32'd0);
        step();
        @(negedge clk);
        chk("cap_held_a2", alu_a, 32'h1234);
        step();
        q.push_back('{32'h1234, 32'h3, 4'b1000, 32'h0, 5'd10, 1'b1,
                      32'h114});
        ex_ready = 1;
        step();

        // Reset while holding
        ex_ready = 0;
        issue(32'h118, 32'h5, 32'h6, 32'h7, 1, 2, 3, 4'b0101, 0, 1, 1);
        @(negedge clk);
        chk("prerst_ex_valid", 32'(ex_valid), 32'd1);
        step();
        rst = 1;
        step();
        rst = 0;
        @(negedge clk);
        chk("midrst_ex_valid", 32'(ex_valid), 32'd0);
        chk("midrst_alu_ctrl", 32'(alu_ctrl), 32'd0);
        chk("midrst_id_ready", 32'(id_ready), 32'd1);
        ex_ready = 1;
        step();

        // Flush with an incoming instruction
        q.push_back('{32'h21, 32'h22, 4'b0001, 32'h22, 5'd11, 1'b1,
                      32'h200});
        issue(32'h200, 32'h21, 32'h22, 0, 1, 2, 11, 4'b0001, 0, 0, 1);
        flush = 1;
        id_valid = 1; id_pc = 32'h204; id_rd_addr = 12;
        step();
        flush = 0; id_valid = 0;
        @(negedge clk);
        chk("flush_ex_valid", 32'(ex_valid), 32'd0);
        chk("flush_reg_write", 32'(ex_reg_write), 32'd0);
        chk("flush_id_ready", 32'(id_ready), 32'd1);
        step(); step();

        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d left expected 0",
                     q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
